// File: rtl/vga_timing_rx.sv
// vga_timing_rx: measures incoming hsync/vsync timing against the expected mode, declares lock,
// and regenerates display-enable and pixel x/y. Define VGA_RX_SYNC2FF_EN for a 2-flop input synchroniser.
//
// state  | meaning
// SEARCH | no lock; first vsync edge arms measurement, next good frame starts checking
// CHECK  | counting consecutive good frames toward LOCK_FRAMES
// LOCKED | mode matched; display enable and pixel coordinates are live

module vga_timing_rx #(
    parameter int   H_DISP      = 1280,
    parameter int   H_FRONT     = 48,
    parameter int   H_SYNC      = 112,
    parameter int   H_BACK      = 248,
    parameter int   V_DISP      = 1024,
    parameter int   V_FRONT     = 1,
    parameter int   V_SYNC      = 3,
    parameter int   V_BACK      = 38,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    output logic        locked,
    output logic        disp_enable,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic [11:0] h_meas,
    output logic [10:0] v_meas,
    output logic        err
);

    localparam int H_TOTAL = H_DISP + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISP + V_FRONT + V_SYNC + V_BACK;
    localparam int HS      = H_SYNC + H_BACK;
    localparam int VS      = V_SYNC + V_BACK;

    localparam logic [11:0] HCNT_MAX  = 12'hFFF;
    localparam logic [10:0] VCNT_MAX  = 11'h7FF;
    localparam logic [11:0] H_TIMEOUT = 12'(2 * H_TOTAL);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    logic hs_in, vs_in;

`ifdef VGA_RX_SYNC2FF_EN
    logic [1:0] hs_meta, vs_meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_meta <= {2{~SYNC_ACTIVE}};
            vs_meta <= {2{~SYNC_ACTIVE}};
        end else begin
            hs_meta <= {hs_meta[0], hsync};
            vs_meta <= {vs_meta[0], vsync};
        end
    end

    assign hs_in = hs_meta[1];
    assign vs_in = vs_meta[1];
`else
    assign hs_in = hsync;
    assign vs_in = vsync;
`endif

    logic hs_s, hs_d, vs_s, vs_d;
    logic hs_edge, vs_edge;

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_s    <= ~SYNC_ACTIVE;
            hs_d    <= ~SYNC_ACTIVE;
            vs_s    <= ~SYNC_ACTIVE;
            vs_d    <= ~SYNC_ACTIVE;
            hs_edge <= 1'b0;
            vs_edge <= 1'b0;
        end else begin
            hs_s    <= hs_in;
            hs_d    <= hs_s;
            vs_s    <= vs_in;
            vs_d    <= vs_s;
            hs_edge <= (hs_s == SYNC_ACTIVE) && (hs_d != SYNC_ACTIVE);
            vs_edge <= (vs_s == SYNC_ACTIVE) && (vs_d != SYNC_ACTIVE);
        end
    end

    logic [11:0] hcnt;
    logic [10:0] vcnt;
    logic [12:0] hcnt_inc;
    logic [11:0] vcnt_inc;
    logic        h_seen;
    logic        line_bad;
    logic        line_short;
    logic        hline_err;
    logic        timeout;
    logic        frame_good;

    assign hcnt_inc   = {1'b0, hcnt} + 13'd1;
    assign vcnt_inc   = {1'b0, vcnt} + 12'd1;
    // The very first hsync edge after reset closes a partial line, so it is not judged.
    assign line_short = h_seen && (hcnt_inc != 13'(H_TOTAL));
    assign hline_err  = hs_edge && line_short;
    assign timeout    = !hs_edge && (hcnt == H_TIMEOUT);
    assign frame_good = (vcnt_inc == 12'(V_TOTAL)) && !line_bad && !hline_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt     <= '0;
            vcnt     <= '0;
            h_meas   <= '0;
            v_meas   <= '0;
            h_seen   <= 1'b0;
            line_bad <= 1'b0;
        end else begin
            if (hs_edge) begin
                hcnt   <= '0;
                h_meas <= hcnt_inc[12] ? HCNT_MAX : hcnt_inc[11:0];
                h_seen <= 1'b1;
            end else if (hcnt != HCNT_MAX) begin
                hcnt <= hcnt_inc[11:0];
            end

            if (vs_edge) begin
                vcnt     <= '0;
                v_meas   <= vcnt_inc[11] ? VCNT_MAX : vcnt_inc[10:0];
                line_bad <= 1'b0;
            end else begin
                if (hs_edge && (vcnt != VCNT_MAX)) begin
                    vcnt <= vcnt_inc[10:0];
                end
                if (hline_err) begin
                    line_bad <= 1'b1;
                end
            end
        end
    end

    state_t     state, state_next;
    logic [3:0] gcnt, gcnt_next;
    logic       armed, armed_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEARCH;
            gcnt  <= '0;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            gcnt  <= gcnt_next;
            armed <= armed_next;
        end
    end

    always_comb begin
        state_next = state;
        gcnt_next  = gcnt;
        armed_next = armed;
        err        = 1'b0;
        case (state)
            SEARCH: begin
                if (timeout) begin
                    armed_next = 1'b0;
                end else if (vs_edge) begin
                    if (!armed) begin
                        armed_next = 1'b1;
                    end else if (frame_good) begin
                        if (LOCK_FRAMES <= 1) begin
                            state_next = LOCKED;
                        end else begin
                            state_next = CHECK;
                            gcnt_next  = 4'd1;
                        end
                    end
                end
            end
            CHECK: begin
                if (timeout || (vs_edge && !frame_good)) begin
                    state_next = SEARCH;
                    gcnt_next  = '0;
                    armed_next = 1'b0;
                end else if (vs_edge) begin
                    gcnt_next = gcnt + 4'd1;
                    if ((gcnt + 4'd1) == 4'(LOCK_FRAMES)) begin
                        state_next = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (hline_err || timeout || (vs_edge && !frame_good)) begin
                    state_next = SEARCH;
                    gcnt_next  = '0;
                    armed_next = 1'b0;
                    err        = 1'b1;
                end
            end
            default: begin
                state_next = SEARCH;
                gcnt_next  = '0;
                armed_next = 1'b0;
            end
        endcase
    end

    assign locked = (state == LOCKED);

    logic h_act, v_act, de_next;

    assign h_act   = (hcnt >= 12'(HS)) && (hcnt < 12'(HS + H_DISP));
    assign v_act   = (vcnt >= 11'(VS)) && (vcnt < 11'(VS + V_DISP));
    assign de_next = locked && h_act && v_act;

    // Coordinates hold their last value outside the active window.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_enable <= 1'b0;
            x           <= '0;
            y           <= '0;
        end else begin
            disp_enable <= de_next;
            if (de_next) begin
                x <= 11'(hcnt - 12'(HS));
                y <= vcnt - 11'(VS);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_rx.sv
// tb_vga_timing_rx: drives a reduced-size VGA sync stream, checks lock/measurement per frame from
// a vector table and checks hsync-edge latency and line length through a scoreboard queue.

module tb_vga_timing_rx;

    localparam int H_DISP = 16, H_FRONT = 4, H_SYNC = 4, H_BACK = 6;
    localparam int V_DISP = 8, V_FRONT = 1, V_SYNC = 2, V_BACK = 3;
    localparam int LOCK_FRAMES = 2;
    localparam int H_TOTAL = H_DISP + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISP + V_FRONT + V_SYNC + V_BACK;
    localparam logic ACT = 1'b0;
`ifdef VGA_RX_SYNC2FF_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        hsync, vsync;
    logic        locked, disp_enable, err;
    logic [10:0] x, y, v_meas;
    logic [11:0] h_meas;

    vga_timing_rx #(
        .H_DISP(H_DISP), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_DISP(V_DISP), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
        .SYNC_ACTIVE(ACT), .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
        .locked(locked), .disp_enable(disp_enable), .x(x), .y(y),
        .h_meas(h_meas), .v_meas(v_meas), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        int meas;
        bit chk;
    } sb_t;

    typedef struct {
        int lines;
        int short_idx;
        int lk;
        int vmeas;
        int errs;
        int de;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[16];

    int checks = 0;
    int fails  = 0;
    int prev_len = 0;
    bit first_line = 1'b1;
    int last_hs_cyc = 0;
    int de_cnt, err_cnt, err_cyc;
    int fx, fy, lx, ly;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic sample();
        if (disp_enable) begin
            if (de_cnt == 0) begin
                fx = int'(x);
                fy = int'(y);
            end
            lx = int'(x);
            ly = int'(y);
            de_cnt++;
        end
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
        end
    endtask

    task automatic clear_stats();
        de_cnt = 0; err_cnt = 0; err_cyc = -1;
        fx = -1; fy = -1; lx = -1; ly = -1;
    endtask

    task automatic send_line(input int len, input bit vs_line);
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            hsync = (c < H_SYNC) ? ACT : !ACT;
            vsync = vs_line ? ACT : !ACT;
            if (c == 0) begin
                sb_q.push_back('{due: cyc + LAT, meas: prev_len, chk: !first_line});
                first_line  = 1'b0;
                last_hs_cyc = cyc;
            end
            sample();
        end
        prev_len = len;
    endtask

    task automatic send_frame(input int lines, input int short_idx);
        clear_stats();
        for (int l = 0; l < lines; l++)
            send_line((l == short_idx) ? H_TOTAL - 1 : H_TOTAL, l < V_SYNC);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hsync = !ACT;
            vsync = !ACT;
            sample();
        end
    endtask

    task automatic run_vec(input int i);
        send_frame(vecs[i].lines, vecs[i].short_idx);
        check($sformatf("v%0d_locked", i), int'(locked), vecs[i].lk);
        check($sformatf("v%0d_v_meas", i), int'(v_meas), vecs[i].vmeas);
        check($sformatf("v%0d_err_pulses", i), err_cnt, vecs[i].errs);
        check($sformatf("v%0d_de_cycles", i), de_cnt, vecs[i].de);
        if (vecs[i].de == H_DISP * V_DISP) begin
            check($sformatf("v%0d_first_x", i), fx, 0);
            check($sformatf("v%0d_first_y", i), fy, 0);
            check($sformatf("v%0d_last_x", i), lx, H_DISP - 1);
            check($sformatf("v%0d_last_y", i), ly, V_DISP - 1);
        end
    endtask

    // Scoreboard consumer: each hs_edge must match the oldest driven leading edge.
    initial begin
        bit  pend;
        int  pend_val;
        sb_t e;
        pend = 1'b0;
        pend_val = 0;
        forever begin
            @(negedge clk);
            if (pend) begin
                check("h_meas", int'(h_meas), pend_val);
                pend = 1'b0;
            end
            if (!rst && dut.hs_edge) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL sb_underflow: actual=hs_edge at cycle %0d required=no edge", cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("hs_edge_latency", cyc, e.due);
                    if (e.chk) begin
                        pend = 1'b1;
                        pend_val = e.meas;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=time limit reached required=bench end");
        $fatal(1, "watchdog");
    end

    initial begin
        // lines, short line index, locked, v_meas, err pulses, display cycles at end of frame
        vecs[0]  = '{V_TOTAL,     -1, 0, 1,           0, 0};
        vecs[1]  = '{V_TOTAL,     -1, 0, V_TOTAL,     0, 0};
        vecs[2]  = '{V_TOTAL,     -1, 1, V_TOTAL,     0, H_DISP * V_DISP};
        vecs[3]  = '{V_TOTAL,     -1, 1, V_TOTAL,     0, H_DISP * V_DISP};
        vecs[4]  = '{V_TOTAL,      7, 0, V_TOTAL,     1, 3 * H_DISP};
        vecs[5]  = '{V_TOTAL,     -1, 0, V_TOTAL,     0, 0};
        vecs[6]  = '{V_TOTAL,     -1, 0, V_TOTAL,     0, 0};
        vecs[7]  = '{V_TOTAL,     -1, 1, V_TOTAL,     0, H_DISP * V_DISP};
        vecs[8]  = '{V_TOTAL + 1, -1, 1, V_TOTAL,     0, H_DISP * V_DISP};
        vecs[9]  = '{V_TOTAL,     -1, 0, V_TOTAL + 1, 1, 0};
        vecs[10] = '{V_TOTAL,     -1, 0, V_TOTAL,     0, 0};
        vecs[11] = '{V_TOTAL - 1, -1, 0, V_TOTAL,     0, 0};
        vecs[12] = '{V_TOTAL,     -1, 0, V_TOTAL - 1, 0, 0};
        vecs[13] = '{V_TOTAL,     -1, 0, V_TOTAL,     0, 0};
        vecs[14] = '{V_TOTAL,     -1, 0, V_TOTAL,     0, 0};
        vecs[15] = '{V_TOTAL,     -1, 1, V_TOTAL,     0, H_DISP * V_DISP};

        rst = 1'b1;
        hsync = !ACT;
        vsync = !ACT;
        clear_stats();
        repeat (3) @(negedge clk);
        check("reset_locked", int'(locked), 0);
        check("reset_disp_enable", int'(disp_enable), 0);
        check("reset_h_meas", int'(h_meas), 0);
        check("reset_v_meas", int'(v_meas), 0);
        check("reset_err", int'(err), 0);
        rst = 1'b0;
        idle(10);

        for (int i = 0; i < 16; i++) run_vec(i);

        // Reset in the middle of a locked frame, stream stalled during reset.
        clear_stats();
        for (int l = 0; l < 7; l++) send_line(H_TOTAL, l < V_SYNC);
        check("pre_reset_locked", int'(locked), 1);
        check("pre_reset_y", int'(y), 1);
        @(negedge clk);
        rst = 1'b1;
        hsync = !ACT;
        vsync = !ACT;
        repeat (5) @(negedge clk);
        check("midrst_locked", int'(locked), 0);
        check("midrst_disp_enable", int'(disp_enable), 0);
        check("midrst_x", int'(x), 0);
        check("midrst_y", int'(y), 0);
        check("midrst_h_meas", int'(h_meas), 0);
        check("midrst_v_meas", int'(v_meas), 0);
        check("midrst_err", int'(err), 0);
        check("midrst_state_search", int'(dut.state), 0);
        check("midrst_sb_empty", sb_q.size(), 0);
        rst = 1'b0;
        sb_q.delete();
        first_line = 1'b1;
        idle(10);
        for (int i = 0; i < 4; i++) run_vec(i);

        // hsync stuck inactive while locked.
        clear_stats();
        idle(4200);
        check("stuck_err_pulses", err_cnt, 1);
        check("stuck_err_offset", err_cyc - last_hs_cyc, 2 * H_TOTAL + 1 + LAT);
        check("stuck_locked", int'(locked), 0);
        check("stuck_hcnt_sat", int'(dut.hcnt), 4095);
        check("stuck_disp_enable", int'(disp_enable), 0);

        idle(5);
        check("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
